hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter TIMEOUT, default 16, memory-wait cycles before error (≥2).
REQ-002 Parameter CNT_W, default 16, statistics counter width.
REQ-003 clk  input  1  rising-edge clock, single domain.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rs1_s2, rs2_s2  input  5 each  source registers of the decode-stage instruction.
REQ-006 rs1_used_s2, rs2_used_s2  input  1 each  the decode-stage instruction reads rs1/rs2.
REQ-007 rd_s3  input  5  execute-stage destination register.
REQ-008 RegWEn_s3, MemRead_s3  input  1 each  execute-stage writes register / is a load.
REQ-009 Branch_taken_s3  input  1  execute-stage redirect (taken branch/jump).
REQ-010 mem_req_s4  input  1  memory-stage access in progress.
REQ-011 mem_ready_s4  input  1  data memory completes the access this cycle.
REQ-012 Stall_F, Stall_D, Stall_E, Stall_M  output  1 each  hold PC, IF/ID, ID/EX and EX/MEM registers.
REQ-013 Bubble_E, Bubble_W  output  1 each  load NOP into ID/EX or MEM/WB.
REQ-014 Flush_D, Flush_E  output  1 each  kill IF/ID and ID/EX contents.
REQ-015 mem_timeout  output  1  sticky memory-timeout error.
REQ-016 loaduse_cnt, flush_cnt  output  CNT_W each  saturating event counters.

Function
REQ-017 The block SHALL handle hazards that forwarding cannot resolve: load-use, redirect and memory wait.
REQ-018 LU = MemRead_s3 & RegWEn_s3 & rd_s3≠0 & ((rs1_used_s2 & rs1_s2==rd_s3) | (rs2_used_s2 & rs2_s2==rd_s3)).
REQ-019 MW = mem_req_s4 & !mem_ready_s4.
REQ-020 FSM states SHALL be RUN and MEM_WAIT; the registered state is updated on the rising edge of clk.
REQ-021 RUN→MEM_WAIT when MW; MEM_WAIT→RUN when mem_ready_s4 or !mem_req_s4; otherwise the state is held.
REQ-022 All stall, bubble and flush outputs SHALL be combinational from the current inputs, effective in the same cycle.
REQ-023 Priority 1: when MW is true, Stall_F/D/E/M=1 and Bubble_W=1; Flush_D/E, Bubble_E=0; LU and redirect are ignored that cycle.
REQ-024 Priority 2: when !MW and Branch_taken_s3, Flush_D=1 and Flush_E=1; the LU stall is suppressed.
REQ-025 Priority 3: when !MW and !Branch_taken_s3 and LU, Stall_F=1, Stall_D=1 and Bubble_E=1 for exactly that cycle.
REQ-026 Otherwise all stall, bubble and flush outputs SHALL be 0.
REQ-027 LU cannot recur the next cycle because the load has advanced to s4; the block adds no extra bubble.
REQ-028 wait_cnt (internal, ⌈log2 TIMEOUT⌉+1 bits) SHALL increment each cycle MW is true, clear when MW is false, and saturate at TIMEOUT.
REQ-029 mem_timeout SHALL set on the edge where wait_cnt==TIMEOUT-1 and MW is still true, then stay set until reset; the stall continues.
REQ-030 loaduse_cnt SHALL increment on every edge where REQ-025 applied; flush_cnt on every edge where REQ-024 applied; both saturate at 2^CNT_W-1.
REQ-031 A mem_ready_s4 arriving in the first request cycle SHALL cause no stall and no MEM_WAIT entry.

Reset
REQ-032 While rst_n=0: state=RUN, wait_cnt=0, mem_timeout=0, loaduse_cnt=0, flush_cnt=0, asynchronously.
REQ-033 All stall, bubble and flush outputs SHALL be forced to 0 while rst_n=0.
REQ-034 Reset asserted during MEM_WAIT SHALL abort the wait; after release the block starts in RUN, regardless of mem_req_s4.
REQ-035 Release is synchronous to clk; the first state update occurs on the first rising edge with rst_n=1.

Verification
REQ-036 Load x5 in s3 (MemRead_s3=1, RegWEn_s3=1, rd_s3=5), rs2_s2=5, rs2_used_s2=1 -> Stall_F=Stall_D=Bubble_E=1 for one cycle; loaduse_cnt 0→1.
REQ-037 Same with rd_s3=0, or rs2_used_s2=0 -> no stall; counter unchanged.
REQ-038 LU and Branch_taken_s3 together -> Flush_D=Flush_E=1, Stall_F=0; flush_cnt +1, loaduse_cnt unchanged.
REQ-039 mem_req_s4=1, mem_ready_s4=0 for 3 cycles, then 1 -> Stall_F/D/E/M=Bubble_W=1 for 3 cycles; RUN→MEM_WAIT→RUN; mem_timeout=0.
REQ-040 TIMEOUT=4, memory never ready -> mem_timeout rises after the 4th wait edge, stalls persist; rst_n pulse clears everything to RUN.
REQ-041 loaduse_cnt forced to 2^CNT_W-1 by repeated LU -> further LU leaves the counter unchanged.

Source files
------------

// File: rtl/hazard_unit_if.sv
// Hazard unit signal bundle: decode/execute/memory-stage hazard inputs and the
// stall, bubble, flush, error and statistics outputs of the hazard unit.
// The pipeline side uses the master modport, the hazard unit the slave modport.
interface hazard_unit_if #(
    parameter int CNT_W = 16
);
    // Decode-stage source operands
    logic [4:0]       rs1_s2;
    logic [4:0]       rs2_s2;
    logic             rs1_used_s2;
    logic             rs2_used_s2;
    // Execute-stage destination / control
    logic [4:0]       rd_s3;
    logic             RegWEn_s3;
    logic             MemRead_s3;
    logic             Branch_taken_s3;
    // Memory-stage handshake
    logic             mem_req_s4;
    logic             mem_ready_s4;
    // Pipeline control outputs
    logic             Stall_F;
    logic             Stall_D;
    logic             Stall_E;
    logic             Stall_M;
    logic             Bubble_E;
    logic             Bubble_W;
    logic             Flush_D;
    logic             Flush_E;
    // Status and statistics
    logic             mem_timeout;
    logic [CNT_W-1:0] loaduse_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output rs1_s2, rs2_s2, rs1_used_s2, rs2_used_s2,
        output rd_s3, RegWEn_s3, MemRead_s3, Branch_taken_s3,
        output mem_req_s4, mem_ready_s4,
        input  Stall_F, Stall_D, Stall_E, Stall_M,
        input  Bubble_E, Bubble_W, Flush_D, Flush_E,
        input  mem_timeout, loaduse_cnt, flush_cnt
    );

    modport slave (
        input  rs1_s2, rs2_s2, rs1_used_s2, rs2_used_s2,
        input  rd_s3, RegWEn_s3, MemRead_s3, Branch_taken_s3,
        input  mem_req_s4, mem_ready_s4,
        output Stall_F, Stall_D, Stall_E, Stall_M,
        output Bubble_E, Bubble_W, Flush_D, Flush_E,
        output mem_timeout, loaduse_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit for hazards forwarding cannot resolve:
//   - memory wait (highest priority): freeze F/D/E/M, bubble into MEM/WB
//   - taken redirect in execute: flush IF/ID and ID/EX
//   - load-use: hold PC and IF/ID for one cycle, bubble into ID/EX
// Pipeline controls are combinational so they act in the cycle the hazard is
// seen. A wait counter flags a sticky timeout when memory never answers, and
// two saturating counters record load-use stalls and redirect flushes.
module hazard_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_unit_if.slave  hz
);

    // Wait counter must be able to hold the value TIMEOUT itself.
    localparam int                WCNT_W   = $clog2(TIMEOUT) + 1;
    localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(TIMEOUT);
    localparam logic [WCNT_W-1:0] WAIT_TO  = WCNT_W'(TIMEOUT - 1);
    localparam logic [WCNT_W-1:0] WAIT_ONE = WCNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    // Saturating increment for the statistics counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        logic [CNT_W-1:0] res;
        if (val == CNT_MAX) begin
            res = val;
        end else begin
            res = val + CNT_ONE;
        end
        return res;
    endfunction

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  loaduse_cnt_q, loaduse_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic              rs1_hit_s;
    logic              rs2_hit_s;
    logic              lu_s;
    logic              mw_s;
    logic              lu_take_s;
    logic              br_take_s;

    logic              stall_f_s;
    logic              stall_d_s;
    logic              stall_e_s;
    logic              stall_m_s;
    logic              bubble_e_s;
    logic              bubble_w_s;
    logic              flush_d_s;
    logic              flush_e_s;

    // Raw hazard detection: load-use dependency and outstanding memory wait.
    always_comb begin
        rs1_hit_s = hz.rs1_used_s2 && (hz.rs1_s2 == hz.rd_s3);
        rs2_hit_s = hz.rs2_used_s2 && (hz.rs2_s2 == hz.rd_s3);
        lu_s      = hz.MemRead_s3 && hz.RegWEn_s3 && (hz.rd_s3 != 5'd0)
                    && (rs1_hit_s || rs2_hit_s);
        mw_s      = hz.mem_req_s4 && !hz.mem_ready_s4;
        // Which lower-priority action actually takes effect this cycle.
        br_take_s = !mw_s && hz.Branch_taken_s3;
        lu_take_s = !mw_s && !hz.Branch_taken_s3 && lu_s;
    end

    // Prioritised stall/bubble/flush generation, forced quiet during reset.
    always_comb begin
        stall_f_s  = 1'b0;
        stall_d_s  = 1'b0;
        stall_e_s  = 1'b0;
        stall_m_s  = 1'b0;
        bubble_e_s = 1'b0;
        bubble_w_s = 1'b0;
        flush_d_s  = 1'b0;
        flush_e_s  = 1'b0;
        if (!rst_n) begin
            stall_f_s = 1'b0;
        end else if (mw_s) begin
            // Memory not answering: freeze everything up to EX/MEM.
            stall_f_s  = 1'b1;
            stall_d_s  = 1'b1;
            stall_e_s  = 1'b1;
            stall_m_s  = 1'b1;
            bubble_w_s = 1'b1;
        end else if (hz.Branch_taken_s3) begin
            // Redirect kills the dependent instruction, so no load-use stall.
            flush_d_s = 1'b1;
            flush_e_s = 1'b1;
        end else if (lu_s) begin
            // One-cycle hold; next cycle the load is in s4 and forwards.
            stall_f_s  = 1'b1;
            stall_d_s  = 1'b1;
            bubble_e_s = 1'b1;
        end else begin
            stall_f_s = 1'b0;
        end
    end

    // Drive the combinational controls and registered status onto the bundle.
    always_comb begin
        hz.Stall_F     = stall_f_s;
        hz.Stall_D     = stall_d_s;
        hz.Stall_E     = stall_e_s;
        hz.Stall_M     = stall_m_s;
        hz.Bubble_E    = bubble_e_s;
        hz.Bubble_W    = bubble_w_s;
        hz.Flush_D     = flush_d_s;
        hz.Flush_E     = flush_e_s;
        hz.mem_timeout = timeout_q;
        hz.loaduse_cnt = loaduse_cnt_q;
        hz.flush_cnt   = flush_cnt_q;
    end

    // Next-state logic for the RUN / MEM_WAIT tracker.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (mw_s) begin
                    state_d = ST_MEM_WAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (hz.mem_ready_s4 || !hz.mem_req_s4) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_MEM_WAIT;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Wait counter and sticky timeout: count consecutive wait cycles, saturating.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        if (!mw_s) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q;
        end else begin
            wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end
        if (mw_s && (wait_cnt_q == WAIT_TO)) begin
            timeout_d = 1'b1;
        end else begin
            timeout_d = timeout_q;
        end
    end

    // Statistics: count edges where a load-use stall or a redirect flush acted.
    always_comb begin
        loaduse_cnt_d = loaduse_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        if (lu_take_s) begin
            loaduse_cnt_d = sat_inc(loaduse_cnt_q);
        end else begin
            loaduse_cnt_d = loaduse_cnt_q;
        end
        if (br_take_s) begin
            flush_cnt_d = sat_inc(flush_cnt_q);
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // State, wait tracking and statistics registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            timeout_q     <= 1'b0;
            loaduse_cnt_q <= '0;
            flush_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_q     <= timeout_d;
            loaduse_cnt_q <= loaduse_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: a hand-written vector table, directed
// multi-cycle sequences (memory wait, timeout, reset abort, saturation) and a
// randomized run, all compared against a behavioural model kept in the bench.
module tb_hazard_unit;

    localparam int TO   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk;
    logic rst_n;

    hazard_unit_if #(.CNT_W(CW)) hif ();

    hazard_unit #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector order: {Stall_F, Stall_D, Stall_E, Stall_M, Bubble_E, Bubble_W, Flush_D, Flush_E}
    localparam logic [7:0] O_NONE = 8'b0000_0000;
    localparam logic [7:0] O_LU   = 8'b1100_1000;
    localparam logic [7:0] O_BR   = 8'b0000_0011;
    localparam logic [7:0] O_MW   = 8'b1111_0100;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       we;
        logic       mr;
        logic       br;
        logic       req;
        logic       rdy;
        logic [7:0] exp;
        string      name;
    } vec_t;

    int n_chk;
    int n_fail;

    // Behavioural model: counts, consecutive wait length, timeout flag, waiting flag.
    int m_lu;
    int m_fl;
    int m_run;
    int m_to;
    int m_wait;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] outs();
        return {hif.Stall_F, hif.Stall_D, hif.Stall_E, hif.Stall_M,
                hif.Bubble_E, hif.Bubble_W, hif.Flush_D, hif.Flush_E};
    endfunction

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                          input logic u2, input logic [4:0] rd, input logic we,
                          input logic mr, input logic br, input logic req, input logic rdy);
        hif.rs1_s2          = rs1;
        hif.rs2_s2          = rs2;
        hif.rs1_used_s2     = u1;
        hif.rs2_used_s2     = u2;
        hif.rd_s3           = rd;
        hif.RegWEn_s3       = we;
        hif.MemRead_s3      = mr;
        hif.Branch_taken_s3 = br;
        hif.mem_req_s4      = req;
        hif.mem_ready_s4    = rdy;
    endtask

    function automatic bit model_mw();
        return hif.mem_req_s4 && !hif.mem_ready_s4;
    endfunction

    function automatic bit model_lu();
        bit hit1, hit2;
        hit1 = hif.rs1_used_s2 && (hif.rs1_s2 == hif.rd_s3);
        hit2 = hif.rs2_used_s2 && (hif.rs2_s2 == hif.rd_s3);
        return hif.MemRead_s3 && hif.RegWEn_s3 && (hif.rd_s3 != 5'd0) && (hit1 || hit2);
    endfunction

    // Expected controls from the priority rules (wait > redirect > load-use).
    function automatic logic [7:0] model_ctrl();
        if (model_mw()) return O_MW;
        if (hif.Branch_taken_s3) return O_BR;
        if (model_lu()) return O_LU;
        return O_NONE;
    endfunction

    // One clock: check controls mid-cycle, advance model over the edge, check status.
    task automatic cycle(input logic [7:0] exp_c, input string nm);
        bit mw, lu, br;
        #3;
        chk({nm, ".ctrl"}, {24'd0, outs()}, {24'd0, exp_c});
        mw = model_mw();
        lu = model_lu();
        br = hif.Branch_taken_s3;
        @(posedge clk);
        #1;
        if (!mw && br) begin
            if (m_fl < CMAX) m_fl++;
        end else if (!mw && lu) begin
            if (m_lu < CMAX) m_lu++;
        end
        m_run  = mw ? m_run + 1 : 0;
        if (m_run == TO) m_to = 1;
        m_wait = mw ? 1 : 0;
        chk({nm, ".state"},   32'(dut.state_q),   32'(m_wait));
        chk({nm, ".timeout"}, 32'(hif.mem_timeout), 32'(m_to));
        chk({nm, ".lu_cnt"},  32'(hif.loaduse_cnt), 32'(m_lu));
        chk({nm, ".fl_cnt"},  32'(hif.flush_cnt),   32'(m_fl));
    endtask

    // Pulse reset for one edge while inputs stay as they are; returns just after an edge.
    task automatic do_reset(input string nm);
        rst_n = 1'b0;
        #3;
        m_lu = 0; m_fl = 0; m_run = 0; m_to = 0; m_wait = 0;
        chk({nm, ".rst_ctrl"},    {24'd0, outs()}, 32'd0);
        chk({nm, ".rst_state"},   32'(dut.state_q), 32'd0);
        chk({nm, ".rst_timeout"}, 32'(hif.mem_timeout), 32'd0);
        chk({nm, ".rst_cnt"},     32'(hif.loaduse_cnt) + 32'(hif.flush_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk({nm, ".rel_state"}, 32'(dut.state_q), 32'd0);
    endtask

    vec_t vecs[12];

    initial begin
        n_chk = 0; n_fail = 0;
        m_lu = 0; m_fl = 0; m_run = 0; m_to = 0; m_wait = 0;

        vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE, "idle"};
        vecs[1]  = '{5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_LU,   "lu_rs2"};
        vecs[2]  = '{5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE, "lu_x0"};
        vecs[3]  = '{5'd0, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE, "lu_unused"};
        vecs[4]  = '{5'd7, 5'd3, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_LU,   "lu_rs1"};
        vecs[5]  = '{5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE, "not_load"};
        vecs[6]  = '{5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE, "no_wen"};
        vecs[7]  = '{5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, O_BR,   "lu_and_br"};
        vecs[8]  = '{5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, O_BR,   "br_only"};
        vecs[9]  = '{5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, O_MW,   "mw_over_all"};
        vecs[10] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, O_LU,   "ready_first"};
        vecs[11] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_NONE, "ready_no_req"};

        // Reset with every hazard asserted: controls must stay low.
        rst_n = 1'b0;
        set_in(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        #2;
        chk("reset.ctrl",    {24'd0, outs()}, 32'd0);
        chk("reset.state",   32'(dut.state_q), 32'd0);
        chk("reset.timeout", 32'(hif.mem_timeout), 32'd0);
        chk("reset.lu_cnt",  32'(hif.loaduse_cnt), 32'd0);
        chk("reset.fl_cnt",  32'(hif.flush_cnt), 32'd0);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #6;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven single-cycle vectors.
        for (int i = 0; i < 12; i++) begin
            set_in(vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].rd,
                   vecs[i].we, vecs[i].mr, vecs[i].br, vecs[i].req, vecs[i].rdy);
            cycle(vecs[i].exp, vecs[i].name);
        end

        // Memory wait of three cycles, then ready: no timeout.
        do_reset("seq_mw");
        for (int i = 0; i < 3; i++) begin
            set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            cycle(O_MW, "mw3");
        end
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cycle(O_NONE, "mw3_ready");
        chk("mw3_no_timeout", 32'(hif.mem_timeout), 32'd0);

        // Memory never ready: timeout after the 4th wait edge, stall persists.
        do_reset("seq_to");
        for (int i = 0; i < 7; i++) begin
            set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            cycle(O_MW, "to_wait");
            if (i == 2) chk("to_before", 32'(hif.mem_timeout), 32'd0);
            if (i == 3) chk("to_after",  32'(hif.mem_timeout), 32'd1);
        end
        // Timeout is sticky once memory recovers.
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(O_NONE, "to_sticky");
        chk("to_sticky_val", 32'(hif.mem_timeout), 32'd1);

        // Reset in the middle of a wait with the request still pending.
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(O_MW, "abort_w0");
        cycle(O_MW, "abort_w1");
        do_reset("seq_abort");
        cycle(O_MW, "abort_post");

        // Load-use counter saturation.
        do_reset("seq_sat");
        for (int i = 0; i < CMAX + 3; i++) begin
            set_in(5'd0, 5'd9, 1'b0, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            cycle(O_LU, "sat_lu");
        end
        chk("sat_lu_value", 32'(hif.loaduse_cnt), 32'(CMAX));
        chk("sat_fl_zero",  32'(hif.flush_cnt),   32'd0);

        // Randomized run against the model.
        do_reset("seq_rand");
        for (int i = 0; i < 400; i++) begin
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0),
                   1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
            cycle(model_ctrl(), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
